// File: rtl/op_pkg.sv
// Shared width and saturation helpers for the parametrised adder tree.
package op_pkg;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) r = i + 1;
        end
        return r;
    endfunction

    function automatic int unsigned sum_w(input int unsigned in_w, input int unsigned n_in);
        return in_w + clog2(n_in);
    endfunction

    // Clamp limits as raw ACC_W-bit patterns, right-aligned in 64 bits.
    function automatic logic [63:0] sat_max(input int unsigned acc_w, input bit sgn);
        if (sgn) return (64'd1 << (acc_w - 1)) - 64'd1;
        return (64'd1 << acc_w) - 64'd1;
    endfunction

    function automatic logic [63:0] sat_min(input int unsigned acc_w, input bit sgn);
        if (sgn) return 64'd1 << (acc_w - 1);
        return 64'd0;
    endfunction

endpackage

// File: rtl/op_add_level.sv
// One registered adder-tree level: N_PAIR adjacent-pair sums, each one bit wider.
module op_add_level #(
    parameter int unsigned N_PAIR = 8,
    parameter int unsigned IN_W   = 12,
    parameter int unsigned SIGNED = 0
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          en,
    input  logic [N_PAIR*2*IN_W-1:0]      d,
    input  logic                          v_in,
    input  logic                          f_in,
    output logic [N_PAIR*(IN_W+1)-1:0]    q,
    output logic                          v_out,
    output logic                          f_out
);

    localparam int unsigned OW = IN_W + 1;

    logic [N_PAIR*OW-1:0] sum_c;

    function automatic logic [OW-1:0] ext(input logic [IN_W-1:0] x);
        if (SIGNED != 0) return OW'($signed(x));
        return OW'(x);
    endfunction

    always_comb begin
        sum_c = '0;
        for (int k = 0; k < int'(N_PAIR); k++) begin
            sum_c[k*OW +: OW] = ext(d[(2*k)*IN_W +: IN_W]) + ext(d[(2*k+1)*IN_W +: IN_W]);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            q     <= '0;
            v_out <= 1'b0;
            f_out <= 1'b0;
        end else if (en) begin
            q     <= sum_c;
            v_out <= v_in;
            f_out <= f_in;
        end
    end

endmodule

// File: rtl/op_addtree.sv
// Pipelined N_IN-operand adder tree with saturating running accumulate and valid/ready flow.
module op_addtree
    import op_pkg::*;
#(
    parameter int unsigned N_IN   = 16,
    parameter int unsigned IN_W   = 12,
    parameter int unsigned SIGNED = 0,
    parameter int unsigned ACC_W  = 20
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [N_IN*IN_W-1:0]   data_in,
    input  logic                   in_valid,
    input  logic                   in_first,
    output logic                   in_ready,
    output logic [ACC_W-1:0]       data_out,
    output logic                   out_valid,
    output logic                   out_sat,
    input  logic                   out_ready
);

    localparam int unsigned LVL   = clog2(N_IN);
    localparam int unsigned SUM_W = sum_w(IN_W, N_IN);
    localparam int unsigned XW    = ACC_W + 1;
    localparam logic [ACC_W-1:0] MAX_V = ACC_W'(sat_max(ACC_W, SIGNED != 0));
    localparam logic [ACC_W-1:0] MIN_V = ACC_W'(sat_min(ACC_W, SIGNED != 0));

    logic en;
    assign en       = out_ready | ~out_valid;
    assign in_ready = en;

    for (genvar i = 0; i < int'(LVL); i++) begin : g_lvl
        localparam int unsigned NP = N_IN >> (i + 1);
        localparam int unsigned IW = IN_W + i;
        logic [NP*2*IW-1:0]  d;
        logic [NP*(IW+1)-1:0] q;
        logic v_i, f_i, v_o, f_o;

        if (i == 0) begin : g_src
            assign d   = data_in;
            assign v_i = in_valid & en;
            assign f_i = in_first & in_valid;
        end else begin : g_chain
            assign d   = g_lvl[i-1].q;
            assign v_i = g_lvl[i-1].v_o;
            assign f_i = g_lvl[i-1].f_o;
        end

        op_add_level #(.N_PAIR(NP), .IN_W(IW), .SIGNED(SIGNED)) u_lvl (
            .clock (clock),
            .reset (reset),
            .en    (en),
            .d     (d),
            .v_in  (v_i),
            .f_in  (f_i),
            .q     (q),
            .v_out (v_o),
            .f_out (f_o)
        );
    end

    logic [SUM_W-1:0] tree_sum;
    logic             tree_v, tree_f;
    assign tree_sum = g_lvl[LVL-1].q;
    assign tree_v   = g_lvl[LVL-1].v_o;
    assign tree_f   = g_lvl[LVL-1].f_o;

    // Overflow test on an ACC_W+1 bit intermediate against the ACC_W output range.
    function automatic logic ovf(input logic [XW-1:0] x);
        if (SIGNED != 0) return x[ACC_W] ^ x[ACC_W-1];
        return x[ACC_W];
    endfunction

    logic [XW-1:0]    sum_x, acc_x, total;
    logic [ACC_W-1:0] acc_d;
    logic             sat_d;

    always_comb begin
        sum_x = XW'(tree_sum);
        acc_x = XW'(data_out);
        if (SIGNED != 0) begin
            sum_x = XW'($signed(tree_sum));
            acc_x = XW'($signed(data_out));
        end
        total = acc_x + sum_x;
        acc_d = ACC_W'(total);
        sat_d = out_sat;
        if (tree_f) begin
            acc_d = ACC_W'(sum_x);
            sat_d = ovf(sum_x);
        end else if (ovf(total)) begin
            acc_d = ((SIGNED != 0) && total[ACC_W]) ? MIN_V : MAX_V;
            sat_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            data_out  <= '0;
            out_valid <= 1'b0;
            out_sat   <= 1'b0;
        end else if (en) begin
            out_valid <= tree_v;
            if (tree_v) begin
                data_out <= acc_d;
                out_sat  <= sat_d;
            end
        end
    end

endmodule

// File: tb/tb_op_addtree.sv
// Directed vectors for op_addtree: unsigned and signed instances share the same stimulus.
`timescale 1ns/1ps
module tb_op_addtree;

    localparam int unsigned N_IN  = 16;
    localparam int unsigned IN_W  = 12;
    localparam int unsigned ACC_W = 20;

    logic                  clock = 1'b0;
    logic                  reset;
    logic [N_IN*IN_W-1:0]  data_in;
    logic                  in_valid, in_first, out_ready;
    logic                  u_in_ready, u_out_valid, u_out_sat;
    logic                  s_in_ready, s_out_valid, s_out_sat;
    logic [ACC_W-1:0]      u_data_out, s_data_out;

    always #5 clock = ~clock;

    op_addtree #(.N_IN(N_IN), .IN_W(IN_W), .SIGNED(0), .ACC_W(ACC_W)) u_dut (
        .clock(clock), .reset(reset), .data_in(data_in), .in_valid(in_valid),
        .in_first(in_first), .in_ready(u_in_ready), .data_out(u_data_out),
        .out_valid(u_out_valid), .out_sat(u_out_sat), .out_ready(out_ready)
    );

    op_addtree #(.N_IN(N_IN), .IN_W(IN_W), .SIGNED(1), .ACC_W(ACC_W)) s_dut (
        .clock(clock), .reset(reset), .data_in(data_in), .in_valid(in_valid),
        .in_first(in_first), .in_ready(s_in_ready), .data_out(s_data_out),
        .out_valid(s_out_valid), .out_sat(s_out_sat), .out_ready(out_ready)
    );

    typedef struct {
        logic             rst_before;
        logic             sgn;
        logic             first;
        logic [IN_W-1:0]  opnd;
        logic [ACC_W-1:0] exp_data;
        logic             exp_sat;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic vec_t mk(input logic rb, input logic sg, input logic fi,
                                input logic [IN_W-1:0] op, input logic [ACC_W-1:0] ed,
                                input logic es);
        vec_t v;
        v.rst_before = rb; v.sgn = sg; v.first = fi;
        v.opnd = op; v.exp_data = ed; v.exp_sat = es;
        return v;
    endfunction

    task automatic do_reset();
        reset = 1'b1; in_valid = 1'b0; in_first = 1'b0; out_ready = 1'b1;
        data_in = '0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    // Drive one beat, then wait (bounded) for the selected instance to present it.
    task automatic send_and_wait(input logic [IN_W-1:0] op, input logic fi, input logic sg,
                                 output int lat, output logic [ACC_W-1:0] d, output logic s);
        data_in = {N_IN{op}}; in_first = fi; in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0; in_first = 1'b0;
        lat = 1;
        while (!(sg ? s_out_valid : u_out_valid) && lat < 20) begin
            @(posedge clock); #1;
            lat++;
        end
        d = sg ? s_data_out : u_data_out;
        s = sg ? s_out_sat : u_out_sat;
    endtask

    initial begin
        int               lat;
        logic [ACC_W-1:0] got_d, held;
        logic             got_s, prev_stall;
        int               ov_seen, sent, rcvd, stalls;
        int unsigned      exp_q[$];

        vecs.push_back(mk(0, 0, 1, 12'hFFF, 20'd65520, 0));
        for (int k = 2; k <= 16; k++) vecs.push_back(mk(0, 0, 0, 12'hFFF, 20'(65520 * k), 0));
        vecs.push_back(mk(0, 0, 0, 12'hFFF, 20'hFFFFF, 1));
        vecs.push_back(mk(0, 0, 1, 12'hFFF, 20'd65520, 0));
        vecs.push_back(mk(0, 1, 1, 12'h800, 20'hF8000, 0));
        for (int k = 1; k <= 16; k++) vecs.push_back(mk(k == 1, 1, 0, 12'h800, 20'(-32768 * k), 0));
        vecs.push_back(mk(0, 1, 0, 12'h800, 20'h80000, 1));
        vecs.push_back(mk(0, 1, 1, 12'h800, 20'hF8000, 0));

        // Reset state, with out_ready low so in_ready reflects out_valid.
        do_reset();
        out_ready = 1'b0;
        @(posedge clock); #1;
        check("rst_data_out", 32'(u_data_out), 32'd0);
        check("rst_out_valid", 32'(u_out_valid), 32'd0);
        check("rst_out_sat", 32'(u_out_sat), 32'd0);
        check("rst_in_ready", 32'(u_in_ready), 32'd1);
        check("rst_in_ready_s", 32'(s_in_ready), 32'd1);
        out_ready = 1'b1;

        foreach (vecs[i]) begin
            if (vecs[i].rst_before) do_reset();
            send_and_wait(vecs[i].opnd, vecs[i].first, vecs[i].sgn, lat, got_d, got_s);
            check($sformatf("row%0d_latency", i), 32'(lat), 32'd5);
            check($sformatf("row%0d_data", i), 32'(got_d), 32'(vecs[i].exp_data));
            check($sformatf("row%0d_sat", i), 32'(got_s), 32'(vecs[i].exp_sat));
            @(posedge clock); #1;
            check($sformatf("row%0d_valid_drop", i),
                  32'(vecs[i].sgn ? s_out_valid : u_out_valid), 32'd0);
            check($sformatf("row%0d_hold", i),
                  32'(vecs[i].sgn ? s_data_out : u_data_out), 32'(vecs[i].exp_data));
        end

        // Mid-stream reset: three beats in flight must never surface.
        do_reset();
        ov_seen = 0;
        for (int c = 0; c < 5; c++) begin
            in_valid = (c < 3); in_first = 1'b1; data_in = {N_IN{12'd9}};
            reset = (c == 4);
            #1;
            if (u_out_valid) ov_seen++;
            @(posedge clock); #1;
        end
        in_valid = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (u_out_valid) ov_seen++;
            @(posedge clock); #1;
        end
        check("rst_discard", 32'(ov_seen), 32'd0);
        send_and_wait(12'd1, 1'b1, 1'b0, lat, got_d, got_s);
        check("post_rst_latency", 32'(lat), 32'd5);
        check("post_rst_data", 32'(got_d), 32'd16);
        check("post_rst_sat", 32'(got_s), 32'd0);

        // Backpressure: continuous beats k=1..8, out_ready low for cycles 7..9.
        @(posedge clock); #1;
        sent = 0; rcvd = 0; stalls = 0; prev_stall = 1'b0; held = '0;
        for (int cyc = 0; cyc < 60 && rcvd < 8; cyc++) begin
            in_valid  = (sent < 8);
            in_first  = 1'b1;
            data_in   = {N_IN{12'(sent + 1)}};
            out_ready = !(cyc >= 7 && cyc <= 9);
            #1;
            if (prev_stall) begin
                check("bp_hold_valid", 32'(u_out_valid), 32'd1);
                check("bp_hold_data", 32'(u_data_out), 32'(held));
            end
            if (u_out_valid && !out_ready) begin
                stalls++;
                check("bp_in_ready", 32'(u_in_ready), 32'd0);
            end
            if (u_out_valid && out_ready) begin
                check("bp_order", 32'(u_data_out),
                      (exp_q.size() > 0) ? 32'(exp_q.pop_front()) : 32'hDEAD);
                rcvd++;
            end
            prev_stall = u_out_valid && !out_ready;
            held       = u_data_out;
            if (in_valid && u_in_ready) begin
                exp_q.push_back(16 * (sent + 1));
                sent++;
            end
            @(posedge clock); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("bp_received", 32'(rcvd), 32'd8);
        check("bp_sent", 32'(sent), 32'd8);
        check("bp_stalls", 32'(stalls), 32'd3);
        check("bp_leftover", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/op_addtree.md
Name: op_addtree

Overview:
- Parametrised, pipelined successor to the fixed 16-input second-stage adder.
- Sums N_IN operands of IN_W bits through a registered binary adder tree.
- Adds an optional running-accumulate stage with saturation, and a valid/ready handshake with backpressure.
- Sits between the first-stage operators and the result/output logic of the datapath.

Parameters:
- N_IN, 16: operand count; power of two, at least 2.
- IN_W, 12: operand width.
- SIGNED, 0: 0 means unsigned operands, 1 means two's-complement operands.
- ACC_W, 20: accumulator and output width; must be at least IN_W+log2(N_IN).

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- data_in  in  N_IN*IN_W  packed operands; operand k occupies bits [k*IN_W +: IN_W].
- in_valid  in  1  data_in is valid this cycle.
- in_first  in  1  this beat starts a new accumulation; qualified by in_valid.
- in_ready  out  1  block accepts a beat this cycle.
- data_out  out  ACC_W  accumulated result.
- out_valid  out  1  data_out is valid.
- out_sat  out  1  sticky saturation flag for the current accumulation.
- out_ready  in  1  downstream accepts data_out.

Behaviour:
- Widths:
  - LVL = log2(N_IN).
  - Each tree level i (1..LVL) adds adjacent pairs and widens by 1 bit, so SUM_W = IN_W+LVL.
  - Extension is sign extension when SIGNED=1, otherwise zero extension.
  - The tree never overflows.
- Pipeline:
  - LVL registered tree levels plus 1 accumulate register.
  - Latency from an accepted beat to out_valid is LVL+1 cycles when not stalled (5 at the defaults).
  - Throughput is 1 beat per cycle.
- Handshake:
  - en = out_ready OR NOT out_valid.
  - in_ready = en (combinational).
  - A beat is accepted when in_valid AND in_ready.
  - All stage registers advance only when en=1; when en=0 every stage holds, including bubbles (no bubble collapse).
  - A valid bit and a first bit travel with every stage.
- Accumulate stage (updates when en=1 and the last tree stage is valid):
  - If first=1: acc = ext(sum); out_sat = 0, then set if ext(sum) is outside the ACC_W range (cannot happen with legal parameters).
  - If first=0: acc = sat(acc + ext(sum)), computed at ACC_W+1 bits.
  - Unsigned saturation clamps to 2^ACC_W-1.
  - Signed saturation clamps to 2^(ACC_W-1)-1 or -2^(ACC_W-1).
  - Any clamp sets out_sat; out_sat stays set until the next first beat.
  - data_out is the acc register.
  - out_valid is 1 in the cycle after a valid beat enters the accumulate stage.
  - When en=1 and no valid beat arrives, out_valid is 0 and data_out holds its value.
- Beat without first:
  - A beat with first=0 after reset (no prior first) accumulates onto acc=0.
  - Plain non-accumulating use: tie in_first=1.
- Reset:
  - All valid bits 0, acc 0, data_out 0, out_sat 0, out_valid 0.
  - in_ready is 1 during the cycle after reset deasserts.
  - A reset mid-stream discards in-flight beats; no partial output appears.
- Simultaneous events:
  - With out_valid=1 and out_ready=1, the block transfers the output and advances in the same cycle.
  - in_first on an idle bubble (in_valid=0) is ignored.

Decomposition:
- Package op_pkg holds:
  - clog2 function;
  - SUM_W derivation;
  - saturation-limit constants as functions of ACC_W and SIGNED.
- Sub-module op_add_level (generic parameters: pair count, input width, SIGNED) implements one registered adder level with valid/first pass-through and an enable input.
- op_addtree instantiates LVL copies of op_add_level in a generate loop, plus the accumulate stage.

Test Plan:
- Defaults, all operands 4095, in_first=1, out_ready=1 -> data_out=65520, out_valid exactly 5 cycles after acceptance, out_sat=0.
- Accumulate run, all operands 4095:
  - first=1 beat followed by 15 first=0 beats -> final data_out=1048320, out_sat=0.
  - A 17th beat (first=0) -> data_out=1048575, out_sat=1.
  - The next first=1 beat -> out_sat=0.
- SIGNED=1, all operands 12'h800, first=1 -> data_out=-32768 sign-extended to 20 bits (0xF8000).
- SIGNED=1, alternating first=0 beats of all -2048 from acc=0 -> saturates at -524288 after 17 beats, out_sat=1.
- Backpressure: continuous beats with operand value = beat index, out_ready held low for 3 cycles -> in_ready low in those cycles, data_out held stable, no beat lost or duplicated, output order preserved.
- Reset asserted 2 cycles after 3 beats were accepted -> no out_valid for those beats; the first post-reset beat (operands 1, first=1) yields data_out=16 after 5 cycles.
